// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// -----------------------------------------------------------------------------
// Frame-sequencing FSM for the UART receiver. It walks a frame through
// START -> DATA -> [PARITY] -> STOP using the external edge/bit counter. It
// also owns that counter's enable. Every sampler, deserialiser and checker
// strobe is decoded combinationally from the state, edge_cnt and bit_cnt.
//
// Optional feature (compile-time macro UART_RX_ERR_CNT_EN):
//   defined   -> adds output err_cnt[7:0]. This is a saturating count of
//                frames that had a parity or stop error.
//   undefined -> no err_cnt port and no counter.
//
// Parameters
//   DATA_WIDTH   data bits per frame, LSB first (legal 5..8)
//
// Ports
//   CLK          in   oversampling clock (Prescale x baud)
//   RST          in   asynchronous, active-low reset
//   RX_IN        in   synchronised serial line, idle high
//   PAR_EN       in   parity bit present (latched at frame start)
//   Prescale     in   oversampling ratio: 8, 16 or 32
//   bit_cnt      in   bit index from the edge/bit counter (start bit = 0)
//   edge_cnt     in   edge index within the current bit
//   strt_glitch  in   start checker: sampled start bit was 1
//   par_err      in   parity checker: mismatch (valid with par_chk_en)
//   stp_err      in   stop checker: sampled stop bit was 0
//   edge_cnt_en  out  counter enable; low clears bit_cnt/edge_cnt
//   dat_samp_en  out  sampler enable around mid-bit (3-sample window)
//   deser_en     out  shift the sampled bit into the deserialiser
//   strt_chk_en  out  start-check strobe
//   par_chk_en   out  parity-check strobe
//   stp_chk_en   out  stop-check strobe
//   data_valid   out  registered 1-cycle pulse: received byte is good
//   par_err_o    out  registered parity error flag, held until next frame
//   stp_err_o    out  registered stop error flag, held until next frame
//   err_cnt      out  (UART_RX_ERR_CNT_EN only) errored-frame count
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic [3:0] bit_cnt,
    input  logic [4:0] edge_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       edge_cnt_en,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       par_err_o,
    output logic       stp_err_o
`ifdef UART_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    // bit_cnt value of the last data bit (the start bit is bit 0).
    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic       par_en_q;

    // -------------------------------------------------------------------------
    // Bit-timing decode. All comparisons are 6 bits wide. edge_cnt is
    // zero-extended so that Prescale=32 (EOB at 31) needs no truncation.
    // -------------------------------------------------------------------------
    logic [5:0] edge_ext;
    logic [5:0] half_bit;
    logic [5:0] cp_val;
    logic [5:0] eob_val;
    logic [5:0] samp_lo;
    logic [5:0] samp_hi;
    logic       at_cp;
    logic       at_eob;
    logic       in_samp_win;

    always_comb begin
        edge_ext    = {1'b0, edge_cnt};
        half_bit    = {1'b0, Prescale[5:1]};
        cp_val      = half_bit + 6'd2;
        eob_val     = Prescale - 6'd1;
        samp_lo     = half_bit - 6'd1;
        samp_hi     = half_bit + 6'd1;
        at_cp       = (edge_ext == cp_val);
        at_eob      = (edge_ext == eob_val);
        in_samp_win = (edge_ext >= samp_lo) && (edge_ext <= samp_hi);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // Falling edges are only looked at here; in any other state
                // RX_IN is ignored.
                if (!RX_IN) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (at_cp && strt_glitch) begin
                    state_nxt = IDLE;
                end else if (at_eob) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (at_eob && (bit_cnt == LAST_DATA_BIT)) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_eob) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Leave at the checkpoint, not at the end of the bit. This
                // lets a back-to-back start bit be seen within half a bit.
                if (at_cp) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Strobe decode (combinational)
    // -------------------------------------------------------------------------
    always_comb begin
        edge_cnt_en = (state != IDLE);
        dat_samp_en = (state != IDLE) && in_samp_win;
        strt_chk_en = (state == START)  && at_cp;
        deser_en    = (state == DATA)   && at_cp;
        par_chk_en  = (state == PARITY) && at_cp;
        stp_chk_en  = (state == STOP)   && at_cp;
    end

    // -------------------------------------------------------------------------
    // State register and PAR_EN latch
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            par_en_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Capture parity mode only at frame start. Later PAR_EN changes
            // do not affect a frame already in flight.
            if ((state == IDLE) && !RX_IN) begin
                par_en_q <= PAR_EN;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered result flags
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_valid <= 1'b0;
            par_err_o  <= 1'b0;
            stp_err_o  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if ((state == IDLE) && !RX_IN) begin
                par_err_o <= 1'b0;
                stp_err_o <= 1'b0;
            end
            if ((state == PARITY) && at_cp && par_err) begin
                par_err_o <= 1'b1;
            end
            if ((state == STOP) && at_cp) begin
                if (stp_err) begin
                    stp_err_o <= 1'b1;
                end
                // par_err_o already holds this frame's parity verdict here.
                data_valid <= !stp_err && !par_err_o;
            end
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    // -------------------------------------------------------------------------
    // Errored-frame counter. It is updated once per frame at the stop
    // checkpoint, so a frame with both errors counts once. A start glitch
    // never reaches STOP, so it is not counted.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            err_cnt <= 8'd0;
        end else if ((state == STOP) && at_cp && (par_err_o || stp_err)
                     && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// -----------------------------------------------------------------------------
// Self-checking bench for uart_rx_ctrl. The bench drives serial frames. It
// plays the role of the edge/bit counter and the checkers: frame position
// comes from plain cycle arithmetic. Every cycle it compares all DUT outputs
// with a timeline model of the frame. Bit b (start = 0) spans P cycles, and
// its checkpoint is at edge P/2+2. The err_cnt port is checked only when the
// DUT is built with UART_RX_ERR_CNT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

    localparam int W = 8;

    // ---------------------------------------------------------------- clock/reset
    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic       PAR_EN;
    logic [5:0] Prescale;
    logic [3:0] bit_cnt;
    logic [4:0] edge_cnt;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       edge_cnt_en;
    logic       dat_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       par_err_o;
    logic       stp_err_o;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    always #5 CLK = ~CLK;

    uart_rx_ctrl #(.DATA_WIDTH(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .Prescale    (Prescale),
        .bit_cnt     (bit_cnt),
        .edge_cnt    (edge_cnt),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt_en (edge_cnt_en),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .par_err_o   (par_err_o),
        .stp_err_o   (stp_err_o)
`ifdef UART_RX_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    // ---------------------------------------------------------------- scoreboard
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];      // expected data_valid pulses per frame
    bit          exp_pe = 1'b0; // model of par_err_o
    bit          exp_se = 1'b0; // model of stp_err_o
    int          exp_cnt = 0;   // model of err_cnt

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {23'd0, edge_cnt_en, dat_samp_en, deser_en, strt_chk_en,
                par_chk_en, stp_chk_en, data_valid, par_err_o, stp_err_o};
    endfunction

    function automatic logic [31:0] pack_exp(bit en, bit samp, bit deser, bit strt,
                                             bit parc, bit stpc, bit dv, bit pe, bit se);
        return {23'd0, en, samp, deser, strt, parc, stpc, dv, pe, se};
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic drive_quiet();
        RX_IN       = 1'b1;
        edge_cnt    = 5'd0;
        bit_cnt     = 4'd0;
        strt_glitch = 1'b0;
        par_err     = 1'b0;
        stp_err     = 1'b0;
    endtask

    // Entered and left at posedge+1.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            drive_quiet();
            @(negedge CLK);
            check("idle", obs(), pack_exp(0, 0, 0, 0, 0, 0, 0, exp_pe, exp_se));
`ifdef UART_RX_ERR_CNT_EN
            check("idle_err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
            @(posedge CLK);
            #1;
        end
    endtask

    // Sends one frame and checks every cycle. j = -1 is the cycle in which
    // the DUT (in IDLE) first sees RX_IN low. j >= 0 counts cycles inside the
    // frame. abort_j >= 0 asserts RST in that cycle and ends the frame there.
    task automatic run_frame(input int p, input logic [7:0] data, input bit par,
                             input bit par_bad_in, input bit stp_bad, input bit glitch,
                             input int abort_j);
        int  h, s, j_end, last_j, pcp, b, e, n_deser, n_dv;
        bit  par_bad, good, in_frame, cp;
        bit  x_en, x_samp, x_deser, x_strt, x_par, x_stp, x_dv;
        logic [31:0] dv_exp;

        par_bad = par_bad_in && par;
        h       = p / 2;
        s       = par ? W + 2 : W + 1;
        j_end   = glitch ? h + 2 : s * p + h + 2;
        last_j  = glitch ? 2 * p - 1 : (s + 1) * p - 1;
        pcp     = (W + 1) * p + h + 2;
        good    = !glitch && !stp_bad && !par_bad;
        n_deser = 0;
        n_dv    = 0;
        exp_q.push_back(good ? 32'd1 : 32'd0);
        Prescale = 6'(p);

        for (int j = -1; j <= last_j; j++) begin
            b        = (j < 0) ? 0 : j / p;
            e        = (j < 0) ? 0 : j % p;
            in_frame = (j >= 0) && (j <= j_end);
            cp       = in_frame && (e == h + 2);

            // Serial line. A bad stop bit is held low only through its
            // checkpoint, so the idle line after it does not start a frame.
            if (j < 0)                     RX_IN = 1'b0;
            else if (glitch)               RX_IN = (j <= 1) ? 1'b0 : 1'b1;
            else if (b == 0)               RX_IN = 1'b0;
            else if (b <= W)               RX_IN = data[b-1];
            else if (par && b == W + 1)    RX_IN = (^data) ^ par_bad;
            else                           RX_IN = !(stp_bad && j <= j_end);

            // PAR_EN matters only at the start; otherwise it is noise.
            PAR_EN      = (j < 0) ? par : 1'($urandom_range(0, 1));
            edge_cnt    = in_frame ? 5'(e) : 5'd0;
            bit_cnt     = in_frame ? 4'(b) : 4'd0;
            strt_glitch = glitch && cp && (b == 0);
            par_err     = par_bad && cp && (b == W + 1);
            stp_err     = stp_bad && !glitch && cp && (b == s);

            if (j == abort_j) begin
                #1 RST = 1'b0;
                #1;
                check("reset_outputs", obs(), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
                check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
                void'(exp_q.pop_back());
                exp_pe  = 1'b0;
                exp_se  = 1'b0;
                exp_cnt = 0;
                drive_quiet();
                @(posedge CLK);
                #1;
                return;
            end

            x_en    = in_frame;
            x_samp  = in_frame && (e >= h - 1) && (e <= h + 1);
            x_strt  = cp && (b == 0);
            x_deser = cp && (b >= 1) && (b <= W);
            x_par   = cp && par && (b == W + 1);
            x_stp   = cp && !glitch && (b == s);
            x_dv    = good && (j == j_end + 1);
            if (j == 0) begin
                exp_pe = 1'b0;
                exp_se = 1'b0;
            end
            if (par_bad && j == pcp + 1) exp_pe = 1'b1;
            if (!glitch && j == j_end + 1) begin
                if (stp_bad) exp_se = 1'b1;
                if ((stp_bad || par_bad) && exp_cnt < 255) exp_cnt++;
            end

            @(negedge CLK);
            check("cycle", obs(), pack_exp(x_en, x_samp, x_deser, x_strt, x_par,
                                           x_stp, x_dv, exp_pe, exp_se));
`ifdef UART_RX_ERR_CNT_EN
            check("err_cnt", 32'(err_cnt), 32'(exp_cnt));
`endif
            n_deser += int'(deser_en);
            n_dv    += int'(data_valid);
            @(posedge CLK);
            #1;
        end
        dv_exp = exp_q.pop_front();
        check("deser_count", 32'(n_deser), glitch ? 32'd0 : 32'(W));
        check("dv_count", 32'(n_dv), dv_exp);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        int   p;
        logic [7:0] d;
        bit   par, pb, sb, gl;

        RST      = 1'b0;
        PAR_EN   = 1'b0;
        Prescale = 6'd8;
        drive_quiet();
        repeat (3) @(negedge CLK);
        check("reset_state", obs(), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(posedge CLK);
        #1 RST = 1'b1;
        idle_cycles(2);

        // Basic frame
        run_frame(8, 8'hA5, 0, 0, 0, 0, -2);
        idle_cycles(2);
        // Parity error
        run_frame(16, 8'h5A, 1, 1, 0, 0, -2);
        idle_cycles(2);
        // Start glitch
        run_frame(16, 8'h00, 0, 0, 0, 1, -2);
        idle_cycles(2);
        // Stop error, then a good frame clears the flags
        run_frame(32, 8'h81, 0, 0, 1, 0, -2);
        idle_cycles(2);
        run_frame(32, 8'h7E, 1, 0, 0, 0, -2);
        // Back-to-back frames with no idle gap
        run_frame(8, 8'h3C, 0, 0, 0, 0, -2);
        run_frame(8, 8'hC3, 0, 0, 0, 0, -2);

        // Randomised frames
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            d   = 8'($urandom_range(0, 255));
            par = 1'($urandom_range(0, 1));
            pb  = ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 3) == 0);
            gl  = ($urandom_range(0, 7) == 0);
            idle_cycles($urandom_range(0, 3));
            run_frame(p, d, par, pb, sb, gl, -2);
        end

        // Reset in DATA at bit_cnt 4, with flags set from an errored frame
        run_frame(16, 8'h55, 1, 1, 1, 0, -2);
        run_frame(16, 8'h99, 0, 0, 0, 0, 4 * 16 + 3);
        repeat (2) begin
            @(negedge CLK);
            check("in_reset", obs(), 32'd0);
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;
        idle_cycles(3);
        run_frame(8, 8'h0F, 1, 0, 0, 0, -2);
        idle_cycles(2);

`ifdef UART_RX_ERR_CNT_EN
        // Saturation
        for (int n = 0; n < 300; n++) begin
            run_frame(8, 8'($urandom_range(0, 255)), 0, 0, 1, 0, -2);
        end
        check("err_cnt_saturated", 32'(err_cnt), 32'd255);
        idle_cycles(2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
